// File: rtl/pcie_os_pkg.sv
// Shared ordered-set constants, field offsets and the consensus FSM state type
// for the Rx TS consensus block.
package pcie_os_pkg;

  localparam logic [7:0] OS_TS1   = 8'h1E;
  localparam logic [7:0] OS_TS2   = 8'h2D;
  localparam logic [7:0] LINK_PAD = 8'hF7;

  localparam int OS_W     = 128;
  localparam int ID_LSB   = 0;
  localparam int LINK_LSB = 8;
  localparam int LANE_LSB = 16;
  localparam int RATE_LSB = 32;

  typedef enum logic [1:0] {IDLE, ARMED, DONE, TOUT} consState_t;

endpackage

// File: rtl/rx_os_lane_counter.sv
// Per-lane run-length counter of consecutive identical TS ordered sets, keeping
// the link and rate fields of the run currently being counted.
module rx_os_lane_counter
  import pcie_os_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             active,
  input  logic             osValid,
  input  logic [7:0]       osId,
  input  logic [7:0]       osLink,
  input  logic [7:0]       osRate,
  input  logic [7:0]       expType,
  input  logic             matchLink,
  input  logic [7:0]       linkNum,
  input  logic [CNT_W-1:0] req,
  output logic             countGeReq,
  output logic [7:0]       link,
  output logic [7:0]       rate
);

  logic [CNT_W-1:0] cnt;
  logic             storedVld;

  // storedVld drops with every non-qualifying OS, so a later OS can only extend
  // a run that is still unbroken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      storedVld <= 1'b0;
      link      <= '0;
      rate      <= '0;
    end else if (clear) begin
      cnt       <= '0;
      storedVld <= 1'b0;
      link      <= '0;
      rate      <= '0;
    end else if (active && osValid) begin
      if (osId != expType) begin
        cnt       <= '0;
        storedVld <= 1'b0;
      end else if (matchLink && (osLink != linkNum)) begin
        cnt       <= '0;
        storedVld <= 1'b0;
      end else if (storedVld && (osLink == link) && (osRate == rate)) begin
        if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
      end else begin
        cnt       <= {{(CNT_W-1){1'b0}}, 1'b1};
        storedVld <= 1'b1;
        link      <= osLink;
        rate      <= osRate;
      end
    end
  end

  assign countGeReq = (cnt >= req);

endmodule

// File: rtl/rx_ts_consensus.sv
// Cross-lane TS consensus: per-lane counters, run FSM with cycle timeout, and
// agreement check of link number / rate ID against the lowest enabled lane.
module rx_ts_consensus
  import pcie_os_pkg::*;
#(
  parameter int NUM_LANES = 16,
  parameter int CNT_W     = 5,
  parameter int TIMEOUT_W = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [7:0]                exp_type,
  input  logic                      match_link,
  input  logic [7:0]                link_num_i,
  input  logic [CNT_W-1:0]          req_count,
  input  logic [TIMEOUT_W-1:0]      timeout_cycles,
  input  logic [NUM_LANES-1:0]      lane_en,
  input  logic [NUM_LANES-1:0]      os_valid,
  input  logic [NUM_LANES*OS_W-1:0] os_data,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout,
  output logic [NUM_LANES-1:0]      lane_ok,
  output logic [7:0]                link_num_o,
  output logic [7:0]                rate_id_o
);

  consState_t           state;
  logic [NUM_LANES-1:0] enQ;
  logic [7:0]           expQ;
  logic                 matchQ;
  logic [CNT_W-1:0]     reqQ;
  logic [TIMEOUT_W-1:0] limitQ;
  logic [TIMEOUT_W-1:0] timer;
  logic [TIMEOUT_W:0]   timerInc;
  logic [NUM_LANES-1:0] laneOkQ;
  logic [NUM_LANES-1:0] geVec;
  logic [7:0]           laneLink [NUM_LANES];
  logic [7:0]           laneRate [NUM_LANES];
  logic [7:0]           refLink;
  logic [7:0]           refRate;
  logic                 agree;
  logic                 consensus;
  logic                 expire;
  logic                 clearLanes;
  logic                 unusedOsBits;

  assign clearLanes   = (state == IDLE) && start && !abort;
  assign unusedOsBits = ^os_data;

  for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
    rx_os_lane_counter #(.CNT_W(CNT_W)) uLane (
      .clk       (clk),
      .reset     (reset),
      .clear     (clearLanes),
      .active    ((state == ARMED) && enQ[g]),
      .osValid   (os_valid[g]),
      .osId      (os_data[g*OS_W + ID_LSB   +: 8]),
      .osLink    (os_data[g*OS_W + LINK_LSB +: 8]),
      .osRate    (os_data[g*OS_W + RATE_LSB +: 8]),
      .expType   (expQ),
      .matchLink (matchQ),
      .linkNum   (link_num_i),
      .req       (reqQ),
      .countGeReq(geVec[g]),
      .link      (laneLink[g]),
      .rate      (laneRate[g])
    );
  end

  // Descending scan leaves the lowest enabled lane as the reference.
  always_comb begin
    refLink = '0;
    refRate = '0;
    agree   = 1'b1;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (enQ[i]) begin
        refLink = laneLink[i];
        refRate = laneRate[i];
      end
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      if (enQ[i] && (!geVec[i] || (laneLink[i] != refLink) || (laneRate[i] != refRate)))
        agree = 1'b0;
    end
    consensus = (enQ != '0) && agree;
  end

  // Compared one bit wider so a limit of all-ones cannot alias through wrap.
  assign timerInc = {1'b0, timer} + 1'b1;
  assign expire   = (limitQ != '0) && (timerInc == {1'b0, limitQ});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      enQ        <= '0;
      expQ       <= '0;
      matchQ     <= 1'b0;
      reqQ       <= '0;
      limitQ     <= '0;
      timer      <= '0;
      laneOkQ    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      link_num_o <= LINK_PAD;
      rate_id_o  <= '0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            enQ    <= lane_en;
            expQ   <= exp_type;
            matchQ <= match_link;
            reqQ   <= (req_count == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : req_count;
            limitQ <= timeout_cycles;
            timer  <= '0;
            if (lane_en == '0) begin
              state   <= TOUT;
              timeout <= 1'b1;
            end else begin
              state <= ARMED;
              busy  <= 1'b1;
            end
          end
        end
        ARMED: begin
          laneOkQ <= geVec;
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (consensus) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            link_num_o <= refLink;
            rate_id_o  <= refRate;
          end else if (expire) begin
            state   <= TOUT;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else if (timer != {TIMEOUT_W{1'b1}}) begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign lane_ok = (state == ARMED) ? geVec : laneOkQ;

endmodule
